// File: rtl/gpio_in_port.sv
// GPIO input port: 2-flop pin sync, rising-edge status (clear-on-read), interrupt mask.
// Read data appears 1 cycle after rd_en with a 1-cycle rd_valid pulse; no backpressure, every strobe is accepted.
module gpio_in_port #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] ADDR_DATA = 32'hABD0,
    parameter logic [31:0] ADDR_EDGE = 32'hABD4,
    parameter logic [31:0] ADDR_MASK = 32'hABD8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_pins,
    input  logic [31:0]      address_gpio,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    output logic [31:0]      dato_gpio,
    output logic             rd_valid,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q, sync3_q;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [1:0]       arm_q, arm_d;
    logic [31:0]      dato_q, dato_d;
    logic             vld_q, vld_d;

    logic             armed;
    logic             rd_edge;
    logic [WIDTH-1:0] rise;
    logic [31:0]      rdata;

    always_comb begin
        // Synchronizer holds reset values for the first edges; suppress the false rise they would show.
        armed   = (arm_q == 2'd3);
        arm_d   = armed ? arm_q : arm_q + 2'd1;
        rise    = armed ? (sync2_q & ~sync3_q) : '0;
        rd_edge = rd_en && (address_gpio == ADDR_EDGE);
        // Set wins over clear: a rise landing on the clearing read stays pending.
        edge_d  = (edge_q & ~{WIDTH{rd_edge}}) | rise;
        mask_d  = (wr_en && (address_gpio == ADDR_MASK)) ? wr_data[WIDTH-1:0] : mask_q;

        rdata = '0;
        if (address_gpio == ADDR_DATA) begin
            rdata[WIDTH-1:0] = sync2_q;
        end else if (address_gpio == ADDR_EDGE) begin
            rdata[WIDTH-1:0] = edge_q;
        end else if (address_gpio == ADDR_MASK) begin
            rdata[WIDTH-1:0] = mask_q;
        end
        dato_d = rd_en ? rdata : dato_q;
        vld_d  = rd_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
            arm_q   <= '0;
            dato_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            sync1_q <= gpio_pins;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            arm_q   <= arm_d;
            dato_q  <= dato_d;
            vld_q   <= vld_d;
        end
    end

    assign dato_gpio = dato_q;
    assign rd_valid  = vld_q;
    assign irq       = |(edge_q & mask_q);

endmodule

// File: tb/tb_gpio_in_port.sv
// Bench for gpio_in_port: directed vector table, reset corner cases, then random traffic vs a history-based model.
module tb_gpio_in_port;

    localparam logic [31:0] AD = 32'hABD0;
    localparam logic [31:0] AE = 32'hABD4;
    localparam logic [31:0] AM = 32'hABD8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpio_pins;
    logic [31:0] address_gpio;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] dato_gpio;
    logic        rd_valid;
    logic        irq;

    gpio_in_port dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gpio_pins    (gpio_pins),
        .address_gpio (address_gpio),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .dato_gpio    (dato_gpio),
        .rd_valid     (rd_valid),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    // Model: pin samples taken at each post-reset edge; sync2 before edge n is the sample of edge n-2.
    logic [31:0] sq[$];
    logic [31:0] m_status, m_mask, m_dato;
    logic        m_vld;

    typedef struct {
        logic [31:0] pins;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] e_dato;
        logic        e_vld;
        logic        e_irq;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        m_status = '0;
        m_mask   = '0;
        m_dato   = '0;
        m_vld    = 1'b0;
    endtask

    task automatic model_edge(input logic [31:0] p, input logic [31:0] a,
                              input logic r, input logic w, input logic [31:0] wd);
        logic [31:0] s2;
        logic [31:0] setb;
        int          sz;
        sz   = sq.size();
        s2   = (sz >= 2) ? sq[sz-2] : 32'h0;
        setb = (sz >= 3) ? (sq[sz-2] & ~sq[sz-3]) : 32'h0;
        m_vld = r;
        if (r) begin
            if (a == AD)      m_dato = s2;
            else if (a == AE) m_dato = m_status;
            else if (a == AM) m_dato = m_mask;
            else              m_dato = 32'h0;
        end
        if (r && a == AE) m_status = 32'h0;
        m_status = m_status | setb;
        if (w && a == AM) m_mask = wd;
        sq.push_back(p);
        if (sq.size() > 3) void'(sq.pop_front());
    endtask

    // Called in the negedge phase; returns in the next negedge phase.
    task automatic step(input logic [31:0] p, input logic [31:0] a,
                        input logic r, input logic w, input logic [31:0] wd);
        gpio_pins    = p;
        address_gpio = a;
        rd_en        = r;
        wr_en        = w;
        wr_data      = wd;
        @(posedge clk);
        model_edge(p, a, r, w, wd);
        #1;
        n_vec++;
        chk("model_dato", dato_gpio, m_dato);
        chk("model_rd_valid", {31'b0, rd_valid}, {31'b0, m_vld});
        chk("model_irq", {31'b0, irq}, {31'b0, |(m_status & m_mask)});
        @(negedge clk);
    endtask

    task automatic setv(input int i, input logic [31:0] p, input logic [31:0] a, input logic r,
                        input logic w, input logic [31:0] wd, input logic [31:0] ed,
                        input logic ev, input logic ei);
        tbl[i].pins = p;  tbl[i].addr = a;  tbl[i].rd = r;  tbl[i].wr = w;
        tbl[i].wdata = wd; tbl[i].e_dato = ed; tbl[i].e_vld = ev; tbl[i].e_irq = ei;
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] a;

        // Vector i is applied before post-reset edge i+1; pins 0xF0 held through reset release.
        setv( 0, 32'hF0, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv( 1, 32'hF0, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv( 2, 32'hF0, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv( 3, 32'hF0, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv( 4, 32'hF0, AD,    1, 0, 0, 32'hF0, 1, 0);
        setv( 5, 32'hF0, AE,    1, 0, 0, 32'h00, 1, 0);
        setv( 6, 32'hF0, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv( 7, 32'hF0, AM,    0, 1, 32'h8, 32'h00, 0, 0);
        setv( 8, 32'hF8, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv( 9, 32'hF8, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv(10, 32'hF8, 32'h0, 0, 0, 0, 32'h00, 0, 1);
        setv(11, 32'hF8, AE,    1, 0, 0, 32'h08, 1, 0);
        setv(12, 32'hF8, AE,    1, 0, 0, 32'h00, 1, 0);
        setv(13, 32'hF8, AD,    1, 0, 0, 32'hF8, 1, 0);
        setv(14, 32'hF8, AM,    1, 0, 0, 32'h08, 1, 0);
        setv(15, 32'hF8, 32'h10, 1, 0, 0, 32'h00, 1, 0);
        setv(16, 32'hF8, 32'hABCD, 0, 1, 32'hFFFF_FFFF, 32'h00, 0, 0);
        setv(17, 32'hF8, AM,    1, 0, 0, 32'h08, 1, 0);
        setv(18, 32'hF8, AM,    1, 1, 32'h20, 32'h08, 1, 0);
        setv(19, 32'hF8, AM,    1, 0, 0, 32'h20, 1, 0);
        setv(20, 32'h08, 32'h0, 0, 0, 0, 32'h20, 0, 0);
        setv(21, 32'h08, 32'h0, 0, 0, 0, 32'h20, 0, 0);
        setv(22, 32'h08, AE,    1, 0, 0, 32'h00, 1, 0);
        setv(23, 32'h28, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv(24, 32'h28, 32'h0, 0, 0, 0, 32'h00, 0, 0);
        setv(25, 32'h28, AE,    1, 0, 0, 32'h00, 1, 1);
        setv(26, 32'h28, AE,    1, 0, 0, 32'h20, 1, 0);

        rst_n = 1'b0;
        gpio_pins = 32'hF0; address_gpio = '0; rd_en = 0; wr_en = 0; wr_data = '0;
        model_reset();
        #3;
        chk("reset_dato", dato_gpio, 32'h0);
        chk("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            step(tbl[i].pins, tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata);
            chk($sformatf("tbl%0d_dato", i), dato_gpio, tbl[i].e_dato);
            chk($sformatf("tbl%0d_rd_valid", i), {31'b0, rd_valid}, {31'b0, tbl[i].e_vld});
            chk($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].e_irq});
        end

        // Status set with irq high, then reset asserted between edges during a read.
        step(32'h28, AM, 0, 1, 32'hFFFF_FFFF);
        step(32'h2A, 32'h0, 0, 0, 0);
        step(32'h2A, 32'h0, 0, 0, 0);
        step(32'h2A, 32'h0, 0, 0, 0);
        chk("pre_reset_irq", {31'b0, irq}, 32'h1);
        chk("pre_reset_dato", dato_gpio, 32'h20);
        rd_en = 1'b1; address_gpio = AD;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_dato", dato_gpio, 32'h0);
        chk("async_reset_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("async_reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        chk("reset_read_suppressed", {31'b0, rd_valid}, 32'h0);
        @(negedge clk);
        rd_en = 1'b0;
        rst_n = 1'b1;
        model_reset();

        p = 32'h2A;
        for (int i = 0; i < 600; i++) begin
            p = p ^ ($urandom & $urandom & $urandom);
            case ($urandom_range(0, 4))
                0:       a = AD;
                1:       a = AE;
                2:       a = AM;
                3:       a = 32'hABCD;
                default: a = $urandom;
            endcase
            step(p, a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_in_port.md
GPIO_IN_PORT -- requirements
Module: gpio_in_port

Interface
REQ-001 Parameter WIDTH, default 32: number of input pins.
REQ-002 Parameter ADDR_DATA, default 32'hABD0: address of the pin-value register (read-only).
REQ-003 Parameter ADDR_EDGE, default 32'hABD4: address of the rising-edge status register (read, clear-on-read).
REQ-004 Parameter ADDR_MASK, default 32'hABD8: address of the interrupt mask register (read/write).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 gpio_pins  input  WIDTH  external pins, asynchronous to clk.
REQ-008 address_gpio  input  32  bus address.
REQ-009 rd_en  input  1  read strobe, sampled on each rising edge.
REQ-010 wr_en  input  1  write strobe, sampled on each rising edge.
REQ-011 wr_data  input  32  write data, bits [WIDTH-1:0] used.
REQ-012 dato_gpio  output  32  registered read data, zero-extended above WIDTH.
REQ-013 rd_valid  output  1  one-cycle pulse marking dato_gpio valid.
REQ-014 irq  output  1  level interrupt = OR of (edge_status AND mask).

Function
REQ-015 Each pin SHALL pass through a two-flop synchronizer (sync1, sync2); a third flop (sync3) SHALL hold the previous sync2 value.
REQ-016 A pin held high before rising edge k SHALL appear in sync2 after edge k+1 and SHALL set its edge_status bit at edge k+2.
REQ-017 edge_status bit i SHALL set when sync2[i]=1 and sync3[i]=0 and detection is armed; it SHALL stay set until cleared by a read.
REQ-018 Falling edges SHALL NOT affect edge_status.
REQ-019 An arm counter (2 bits) SHALL disable edge detection for the first 3 rising edges after rst_n deasserts; detection is armed from the 4th edge onward, so pins high at reset release produce no edge.
REQ-020 Read: rd_en=1 at edge n SHALL update dato_gpio and pulse rd_valid=1 after edge n, for exactly one cycle; read latency is 1 cycle.
REQ-021 Read data SHALL be sync2 for ADDR_DATA, edge_status for ADDR_EDGE, mask for ADDR_MASK, and 0 for any other address (rd_valid still pulses).
REQ-022 dato_gpio SHALL hold its last value when no read occurs.
REQ-023 A read of ADDR_EDGE SHALL return the pre-edge status and clear those bits at the same edge.
REQ-024 If a new rising edge and a clear hit the same bit in the same cycle, set SHALL win; the bit stays 1 and is not in the returned data.
REQ-025 Write: wr_en=1 with address_gpio=ADDR_MASK SHALL load mask from wr_data[WIDTH-1:0]; writes to any other address SHALL be ignored.
REQ-026 Simultaneous rd_en and wr_en to ADDR_MASK SHALL return the old mask and load the new one.
REQ-027 irq SHALL be derived from registered edge_status and mask only, with no combinational path from bus inputs.

Reset
REQ-028 While rst_n=0, SHALL clear sync1, sync2, sync3, edge_status, mask, arm counter, dato_gpio, rd_valid, and irq to 0, immediately and without waiting for clk.
REQ-029 Reset asserted mid-read SHALL suppress rd_valid; after release, behaviour SHALL restart per REQ-019.

Verification
REQ-030 Pins=32'h0000_00F0 held through reset release, read ADDR_DATA after 4 edges -> dato_gpio=32'h0000_00F0, rd_valid pulse; read ADDR_EDGE -> 0.
REQ-031 Armed, pin 3 goes 0->1 before edge k -> edge_status[3]=1 after edge k+2; read ADDR_EDGE -> 32'h8; second read -> 0.
REQ-032 Write mask 32'h8 then pin 3 rises -> irq=1 two edges after sync; read ADDR_EDGE clears -> irq=0 next cycle.
REQ-033 Pin 5 edge sets in the same cycle a read of ADDR_EDGE clears it -> returned bit 5=0, edge_status[5] remains 1.
REQ-034 Read address 32'h0000_0010 -> dato_gpio=0, rd_valid=1; write to 32'habcd -> mask unchanged.
REQ-035 Assert rst_n=0 between clock edges with status set -> all outputs 0 immediately.
